// File: rtl/mem_req_ctrl.sv
// mem_req_ctrl: accepts single read/write requests, presents each one to the
// memory for exactly one cycle, waits out the read latency and returns read
// data on a valid/ready response channel. Keeps saturating op counters.
module mem_req_ctrl #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic                  mem_rd_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_enable,
  input  logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic [CNT_WIDTH-1:0]  wr_cnt,
  output logic [CNT_WIDTH-1:0]  rd_cnt
);

  // Latency counter only needs to hold RD_LATENCY-1, at most 6.
  localparam int LAT_W = 3;
  localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(RD_LATENCY - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WAIT,
    RESP
  } state_t;

  state_t           state_reg;
  state_t           state_next;
  logic [LAT_W-1:0] lat_cnt_reg;
  logic             accept;

  // The only combinational output: ready while idle and not held in reset.
  assign req_ready = (state_reg == IDLE) && !rst;
  assign accept    = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: one pass through WR or RD/WAIT/RESP per request.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = req_write ? WR : RD;
        end
      end
      WR:   state_next = IDLE;
      RD:   state_next = WAIT;
      WAIT: begin
        if (lat_cnt_reg == '0) begin
          state_next = RESP;
        end
      end
      RESP: begin
        if (rsp_valid && rsp_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Registered memory bus, response channel, latency counter and op counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_wr_data <= '0;
      mem_enable  <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= '0;
      wr_cnt      <= '0;
      rd_cnt      <= '0;
      lat_cnt_reg <= '0;
    end else begin
      // Strobes are high only in the cycle right after acceptance; both
      // derive from the same accept, so they can never overlap.
      mem_wr_en  <= accept && req_write;
      mem_rd_en  <= accept && !req_write;
      mem_enable <= accept;
      // Address and write data stay put between transactions.
      if (accept) begin
        mem_addr    <= req_addr;
        mem_wr_data <= req_wdata;
      end
      case (state_reg)
        WR: begin
          if (wr_cnt != '1) begin
            wr_cnt <= wr_cnt + CNT_WIDTH'(1);
          end
        end
        RD: begin
          lat_cnt_reg <= LAT_LOAD;
        end
        WAIT: begin
          if (lat_cnt_reg == '0) begin
            rsp_data  <= mem_rd_data;
            rsp_valid <= 1'b1;
          end else begin
            lat_cnt_reg <= lat_cnt_reg - LAT_W'(1);
          end
        end
        RESP: begin
          if (rsp_valid && rsp_ready) begin
            rsp_valid <= 1'b0;
            if (rd_cnt != '1) begin
              rd_cnt <= rd_cnt + CNT_WIDTH'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Bench for mem_req_ctrl: two instances (latency 1 / 16-bit counters and
// latency 3 / 2-bit counters), each with its own behavioural memory.
module tb_mem_req_ctrl;

  logic              clk;
  logic [1:0]        rst;
  logic [1:0]        req_valid;
  logic [1:0]        req_ready;
  logic [1:0]        req_write;
  logic [1:0][2:0]   req_addr;
  logic [1:0][7:0]   req_wdata;
  logic [1:0]        rsp_valid;
  logic [1:0]        rsp_ready;
  logic [1:0][7:0]   rsp_data;
  logic [1:0][2:0]   mem_addr;
  logic [1:0]        mem_wr_en;
  logic [1:0]        mem_rd_en;
  logic [1:0][7:0]   mem_wr_data;
  logic [1:0]        mem_enable;
  logic [1:0][7:0]   mem_rd_data;
  logic [1:0][15:0]  wr_cnt;
  logic [1:0][15:0]  rd_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents and operation totals per instance.
  logic [7:0] ref_mem [2][8];
  int         ref_wr [2];
  int         ref_rd [2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_dut
      localparam int LAT = (gi == 0) ? 1 : 3;
      localparam int CW  = (gi == 0) ? 16 : 2;
      logic [CW-1:0] wc;
      logic [CW-1:0] rc;
      logic [7:0]    mem [8];
      logic [7:0]    pipe [LAT];

      mem_req_ctrl #(
        .ADDR_WIDTH(3),
        .DATA_WIDTH(8),
        .RD_LATENCY(LAT),
        .CNT_WIDTH (CW)
      ) dut (
        .clk        (clk),
        .rst        (rst[gi]),
        .req_valid  (req_valid[gi]),
        .req_ready  (req_ready[gi]),
        .req_write  (req_write[gi]),
        .req_addr   (req_addr[gi]),
        .req_wdata  (req_wdata[gi]),
        .rsp_valid  (rsp_valid[gi]),
        .rsp_ready  (rsp_ready[gi]),
        .rsp_data   (rsp_data[gi]),
        .mem_addr   (mem_addr[gi]),
        .mem_wr_en  (mem_wr_en[gi]),
        .mem_rd_en  (mem_rd_en[gi]),
        .mem_wr_data(mem_wr_data[gi]),
        .mem_enable (mem_enable[gi]),
        .mem_rd_data(mem_rd_data[gi]),
        .wr_cnt     (wc),
        .rd_cnt     (rc)
      );

      assign wr_cnt[gi] = 16'(wc);
      assign rd_cnt[gi] = 16'(rc);

      // Memory: data appears LAT cycles after the read strobe cycle and is
      // random noise in every other cycle, so a mistimed sample is visible.
      always @(posedge clk) begin
        if (mem_enable[gi] && mem_wr_en[gi]) mem[mem_addr[gi]] <= mem_wr_data[gi];
        pipe[0] <= (mem_enable[gi] && mem_rd_en[gi]) ? mem[mem_addr[gi]] : 8'($urandom);
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
      end
      assign mem_rd_data[gi] = pipe[LAT-1];
    end
  endgenerate

  function automatic int lat_of(int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic logic [31:0] sat(int d, int n);
    int m;
    m = (d == 0) ? 65535 : 3;
    return (n > m) ? 32'(m) : 32'(n);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, int d, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, d, obs, exp);
    end
  endtask

  task automatic chk_zero(string tag, int d);
    chk({tag, "_mem_addr"}, d, 32'(mem_addr[d]), 0);
    chk({tag, "_wr_en"}, d, 32'(mem_wr_en[d]), 0);
    chk({tag, "_rd_en"}, d, 32'(mem_rd_en[d]), 0);
    chk({tag, "_wr_data"}, d, 32'(mem_wr_data[d]), 0);
    chk({tag, "_enable"}, d, 32'(mem_enable[d]), 0);
    chk({tag, "_rsp_valid"}, d, 32'(rsp_valid[d]), 0);
    chk({tag, "_rsp_data"}, d, 32'(rsp_data[d]), 0);
    chk({tag, "_wr_cnt"}, d, 32'(wr_cnt[d]), 0);
    chk({tag, "_rd_cnt"}, d, 32'(rd_cnt[d]), 0);
    chk({tag, "_req_ready"}, d, 32'(req_ready[d]), 0);
  endtask

  task automatic do_write(int d, logic [2:0] a, logic [7:0] w);
    chk("wr_pre_ready", d, 32'(req_ready[d]), 1);
    req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = a; req_wdata[d] = w;
    step();
    req_valid[d] = 1'b0;
    chk("wr_strobe", d, 32'(mem_wr_en[d]), 1);
    chk("wr_no_rd", d, 32'(mem_rd_en[d]), 0);
    chk("wr_enable", d, 32'(mem_enable[d]), 1);
    chk("wr_addr", d, 32'(mem_addr[d]), 32'(a));
    chk("wr_data", d, 32'(mem_wr_data[d]), 32'(w));
    chk("wr_busy", d, 32'(req_ready[d]), 0);
    step();
    ref_mem[d][a] = w;
    ref_wr[d]++;
    chk("wr_done_strobe", d, 32'(mem_wr_en[d]), 0);
    chk("wr_done_ready", d, 32'(req_ready[d]), 1);
    chk("wr_cnt", d, 32'(wr_cnt[d]), sat(d, ref_wr[d]));
    $display("dut%0d write addr=%0d data=%02h wr_cnt=%0d", d, a, w, wr_cnt[d]);
  endtask

  task automatic do_read(int d, logic [2:0] a, int bp);
    logic [7:0] exp_data;
    exp_data = ref_mem[d][a];
    chk("rd_pre_ready", d, 32'(req_ready[d]), 1);
    req_valid[d] = 1'b1; req_write[d] = 1'b0; req_addr[d] = a; req_wdata[d] = 8'($urandom);
    step();
    req_valid[d] = 1'b0;
    chk("rd_strobe", d, 32'(mem_rd_en[d]), 1);
    chk("rd_no_wr", d, 32'(mem_wr_en[d]), 0);
    chk("rd_enable", d, 32'(mem_enable[d]), 1);
    chk("rd_addr", d, 32'(mem_addr[d]), 32'(a));
    chk("rd_busy", d, 32'(req_ready[d]), 0);
    for (int k = 0; k < lat_of(d); k++) begin
      step();
      chk("rd_wait_valid", d, 32'(rsp_valid[d]), 0);
      chk("rd_wait_enable", d, 32'(mem_enable[d]), 0);
    end
    step();
    chk("rsp_valid_rise", d, 32'(rsp_valid[d]), 1);
    chk("rsp_data", d, 32'(rsp_data[d]), 32'(exp_data));
    for (int k = 0; k < bp; k++) begin
      step();
      chk("bp_valid", d, 32'(rsp_valid[d]), 1);
      chk("bp_data", d, 32'(rsp_data[d]), 32'(exp_data));
      chk("bp_busy", d, 32'(req_ready[d]), 0);
    end
    rsp_ready[d] = 1'b1;
    step();
    rsp_ready[d] = 1'b0;
    ref_rd[d]++;
    chk("rsp_drop", d, 32'(rsp_valid[d]), 0);
    chk("rd_done_ready", d, 32'(req_ready[d]), 1);
    chk("rd_cnt", d, 32'(rd_cnt[d]), sat(d, ref_rd[d]));
    $display("dut%0d read addr=%0d data=%02h bp=%0d rd_cnt=%0d", d, a, rsp_data[d], bp, rd_cnt[d]);
  endtask

  // Bus invariants, every cycle on both instances.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      checks++;
      assert (!(mem_wr_en[d] === 1'b1 && mem_rd_en[d] === 1'b1)) else begin
        errors++;
        $error("FAIL strobe_overlap dut%0d observed=both expected=one", d);
      end
      checks++;
      assert (mem_enable[d] === (mem_wr_en[d] | mem_rd_en[d])) else begin
        errors++;
        $error("FAIL enable_eq dut%0d observed=%b expected=%b", d, mem_enable[d],
               mem_wr_en[d] | mem_rd_en[d]);
      end
    end
  end

  initial begin
    rst = 2'b11; req_valid = 2'b11; req_write = '0; req_addr = '0;
    req_wdata = '0; rsp_ready = '0;
    for (int d = 0; d < 2; d++) begin ref_wr[d] = 0; ref_rd[d] = 0; end

    // Reset with a request pending: never accepted, everything zero.
    repeat (2) begin
      step();
      for (int d = 0; d < 2; d++) chk_zero("reset", d);
    end
    rst = 2'b00; req_valid = 2'b00;
    #1;
    for (int d = 0; d < 2; d++) chk("post_reset_ready", d, 32'(req_ready[d]), 1);
    $display("reset released");

    // Latency 1: write then read back.
    do_write(0, 3'd3, 8'hA5);
    do_read(0, 3'd3, 0);

    // Latency 3: read of the top address with four cycles of backpressure.
    do_write(1, 3'd7, 8'h3C);
    do_read(1, 3'd7, 4);

    // Reset while the read is waiting on memory: response never appears.
    req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = 3'd7;
    step();
    req_valid[1] = 1'b0;
    step();
    chk("abort_pre_valid", 1, 32'(rsp_valid[1]), 0);
    rst[1] = 1'b1;
    step();
    chk_zero("abort_reset", 1);
    rst[1] = 1'b0;
    ref_wr[1] = 0; ref_rd[1] = 0;
    repeat (6) begin
      step();
      chk("abort_no_rsp", 1, 32'(rsp_valid[1]), 0);
    end
    chk("abort_rd_cnt", 1, 32'(rd_cnt[1]), 0);
    chk("abort_ready", 1, 32'(req_ready[1]), 1);
    $display("dut1 read aborted by reset");
    do_read(1, 3'd7, 1);

    // Back-to-back writes with req_valid held: one accept every two cycles,
    // 2-bit write counter saturates at 3.
    req_valid[1] = 1'b1; req_write[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      req_addr[1] = 3'(i); req_wdata[1] = 8'(8'h10 + i);
      chk("b2b_ready", 1, 32'(req_ready[1]), 1);
      step();
      chk("b2b_strobe", 1, 32'(mem_wr_en[1]), 1);
      chk("b2b_addr", 1, 32'(mem_addr[1]), 32'(i));
      chk("b2b_busy", 1, 32'(req_ready[1]), 0);
      ref_mem[1][i] = 8'(8'h10 + i);
      ref_wr[1]++;
      if (i == 4) req_valid[1] = 1'b0;
      step();
      chk("b2b_wr_cnt", 1, 32'(wr_cnt[1]), sat(1, ref_wr[1]));
      $display("dut1 b2b write addr=%0d wr_cnt=%0d", i, wr_cnt[1]);
    end
    step();
    chk("b2b_idle", 1, 32'(mem_wr_en[1]), 0);

    // Randomized traffic checked against the reference memory and counters.
    for (int d = 0; d < 2; d++) begin
      for (int a = 0; a < 8; a++) do_write(d, 3'(a), 8'($urandom));
      for (int n = 0; n < 30; n++) begin
        repeat ($urandom_range(0, 2)) step();
        if ($urandom_range(0, 1) == 1) do_write(d, 3'($urandom), 8'($urandom));
        else do_read(d, 3'($urandom), int'($urandom_range(0, 3)));
      end
    end

    repeat (2) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_req_ctrl.md
Name: mem_req_ctrl

Overview:
Request-side controller that sits directly upstream of the memory-lab memory and drives its bus: addr, wr_en, rd_en, wr_data, enable. It also consumes rd_data.
It accepts single read/write requests on a valid/ready handshake and issues them to memory one at a time. wr_en and rd_en are mutually exclusive by construction.
It waits out the memory read latency, then returns read data on a valid/ready response channel.
It keeps saturating write and read operation counters for bench scoreboarding.

Parameters:
ADDR_WIDTH, 3, memory address width.
DATA_WIDTH, 8, memory data width.
RD_LATENCY, 1, cycles from mem_rd_en high to mem_rd_data valid; legal range 1..7.
CNT_WIDTH, 16, width of the saturating op counters.

Ports:
clk  input  1  single clock; all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req_valid  input  1  request present.
req_ready  output  1  controller can accept a request.
req_write  input  1  1 = write, 0 = read.
req_addr  input  ADDR_WIDTH  request address.
req_wdata  input  DATA_WIDTH  write data; ignored for reads.
rsp_valid  output  1  read response present.
rsp_ready  input  1  consumer accepts the response.
rsp_data  output  DATA_WIDTH  read data.
mem_addr  output  ADDR_WIDTH  memory address.
mem_wr_en  output  1  memory write strobe.
mem_rd_en  output  1  memory read strobe.
mem_wr_data  output  DATA_WIDTH  memory write data.
mem_enable  output  1  high for exactly the cycle a transaction is presented to memory.
mem_rd_data  input  DATA_WIDTH  memory read data.
wr_cnt  output  CNT_WIDTH  completed writes, saturating.
rd_cnt  output  CNT_WIDTH  completed reads (response accepted), saturating.

Behaviour:
- Reset (rst high at an edge):
  - state <- IDLE.
  - mem_addr, mem_wr_en, mem_rd_en, mem_wr_data, mem_enable, rsp_valid, rsp_data, wr_cnt, rd_cnt all <- 0.
  - req_ready = (state==IDLE) && !rst, so it is 0 in every cycle rst is high.
- All outputs are registered except req_ready.
- FSM states: IDLE, WR, RD, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid && req_ready at edge N: latch addr and wdata into mem_addr/mem_wr_data.
  - Go to WR if req_write, else RD.
- WR (cycle N+1):
  - mem_wr_en=1, mem_enable=1, mem_rd_en=0.
  - Next edge: wr_cnt+1 (saturating at all-ones), strobes <- 0, IDLE.
  - Next request is accepted no earlier than cycle N+2.
- RD (cycle N+1):
  - mem_rd_en=1, mem_enable=1, mem_wr_en=0.
  - Load latency counter with RD_LATENCY-1, go to WAIT.
- WAIT:
  - Strobes 0.
  - Counter at 0: capture mem_rd_data into rsp_data, set rsp_valid, go to RESP.
  - Otherwise decrement.
  - Net effect: data is sampled in cycle N+1+RD_LATENCY; rsp_valid is high from cycle N+2+RD_LATENCY.
- RESP:
  - rsp_valid=1; rsp_data held stable until rsp_valid && rsp_ready.
  - On handshake: rsp_valid <- 0, rd_cnt+1 (saturating), IDLE.
  - Backpressure of any length is legal.
- mem_addr and mem_wr_data hold their last values outside WR/RD; only the strobes return to 0.
- mem_wr_en && mem_rd_en is never 1 in the same cycle.
- mem_enable == mem_wr_en | mem_rd_en in every cycle.
- Requests are never dropped: req_ready=0 outside IDLE, so the requester holds its request.
- Addresses use the full ADDR_WIDTH range; no wrap logic. Address 2^ADDR_WIDTH-1 is legal.
- Reset mid-operation (any non-IDLE state):
  - Transaction abandoned; a pending response is discarded (rsp_valid never rises for it).
  - Strobes are 0 from the edge where rst is sampled.
  - Counters clear.
- A request presented during reset is not accepted.

Test Plan:
1. Reset: rst high 2 cycles with req_valid=1 -> req_ready=0 and all outputs 0 throughout. req_ready=1 in the first cycle after rst falls.
2. Write addr=3, wdata=0xA5 accepted at edge 0 -> cycle 1: mem_wr_en=1, mem_enable=1, mem_rd_en=0, mem_addr=3, mem_wr_data=0xA5. Cycle 2: strobes 0, req_ready=1, wr_cnt=1.
3. Read addr=3, RD_LATENCY=1, memory model returns 0xA5 -> cycle 1: mem_rd_en=1. rsp_valid=1 with rsp_data=0xA5 in cycle 3. With rsp_ready=1: rd_cnt=1 and req_ready=1 in cycle 4.
4. RD_LATENCY=3, read addr=7 returning 0x3C -> rsp_valid first high in cycle 5, rsp_data=0x3C. rsp_ready held 0 for 4 cycles: rsp_valid and rsp_data stable, req_ready=0. After release, IDLE on the next edge.
5. rst asserted in WAIT (RD_LATENCY=3) -> rsp_valid never asserts for that read. rd_cnt=0. Next read completes normally.
6. CNT_WIDTH=2: writes to addr 0..4 back-to-back with req_valid held -> one accept every 2 cycles. wr_cnt goes 1, 2, 3, 3, 3 (saturated). wr_en/rd_en never both high (assertion checked all cycles).
